// File: rtl/data_mem_bank.sv
// data_mem_bank: parametrised data memory with one synchronous write port,
// two registered read ports and write-to-read forwarding. An init sequencer
// loads mem[i] = i after reset or on init_req and holds ready low meanwhile.
// Optional per-byte write enables: define DATA_MEM_BANK_BYTE_EN.
module data_mem_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init_req,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
`ifdef DATA_MEM_BANK_BYTE_EN
  input  logic [DATA_W/8-1:0]      wr_be,
`endif
  input  logic [ADDR_W-1:0]        rd_a_addr,
  input  logic [ADDR_W-1:0]        rd_b_addr,
  output logic signed [DATA_W-1:0] rd_a_data,
  output logic signed [DATA_W-1:0] rd_b_data,
  output logic                     ready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [DATA_W-1:0]   merged;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // Counter zero-extended to the word width, or truncated when DATA_W < ADDR_W.
  logic [DATA_W+ADDR_W-1:0] init_ext;
  logic [DATA_W-1:0]        init_word;

  assign init_ext  = {{DATA_W{1'b0}}, cnt_q};
  assign init_word = init_ext[DATA_W-1:0];
  assign ready     = (state_q == ST_RUN);

  // State and init counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: INIT walks every address once, RUN waits for init_req.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Word a RUN-time write produces; also the value forwarded to matching reads.
  always_comb begin
    merged = wr_data;
`ifdef DATA_MEM_BANK_BYTE_EN
    merged = mem[wr_addr];
    for (int unsigned k = 0; k < DATA_W / 8; k++) begin
      if (wr_be[k]) merged[k*8 +: 8] = wr_data[k*8 +: 8];
    end
`endif
  end

  // Array write port is shared between the init sequencer and the user port.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = merged;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = init_word;
    end else begin
      mem_we    = wr_en;
    end
  end

  // Storage array; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Registered read ports with same-cycle write forwarding; zero during INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a_data <= '0;
      rd_b_data <= '0;
    end else if (state_q == ST_INIT) begin
      rd_a_data <= '0;
      rd_b_data <= '0;
    end else begin
      rd_a_data <= (wr_en && (wr_addr == rd_a_addr)) ? merged : mem[rd_a_addr];
      rd_b_data <= (wr_en && (wr_addr == rd_b_addr)) ? merged : mem[rd_b_addr];
    end
  end

endmodule

// File: tb/tb_data_mem_bank.sv
// Directed self-checking bench for data_mem_bank (DATA_W=32, ADDR_W=5).
module tb_data_mem_bank;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               init_req;
  logic               wr_en;
  logic [4:0]         wr_addr;
  logic signed [31:0] wr_data;
`ifdef DATA_MEM_BANK_BYTE_EN
  logic [3:0]         wr_be;
`endif
  logic [4:0]         rd_a_addr;
  logic [4:0]         rd_b_addr;
  logic signed [31:0] rd_a_data;
  logic signed [31:0] rd_b_data;
  logic               ready;

  int n_chk = 0;
  int n_err = 0;
  int cnt;

  data_mem_bank #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_req  (init_req),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
`ifdef DATA_MEM_BANK_BYTE_EN
    .wr_be     (wr_be),
`endif
    .rd_a_addr (rd_a_addr),
    .rd_b_addr (rd_b_addr),
    .rd_a_data (rd_a_data),
    .rd_b_data (rd_b_data),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until ready rises, bounded so a stuck FSM cannot hang the run.
  task automatic wait_ready(output int edges);
    edges = 0;
    while (!ready && edges < 100) begin
      step();
      edges++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    init_req  = 1'b0;
    wr_en     = 1'b1;
    wr_addr   = 5'd7;
    wr_data   = 32'h0000_1234;
`ifdef DATA_MEM_BANK_BYTE_EN
    wr_be     = 4'hF;
`endif
    rd_a_addr = 5'd7;
    rd_b_addr = 5'd31;

    // Reset state
    step();
    step();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rd_a", rd_a_data, 32'd0);
    chk("rst_rd_b", rd_b_data, 32'd0);

    // Init with wr_en held high; the writes must be ignored
    rst_n = 1'b1;
    wait_ready(cnt);
    chk("init_edges", 32'(cnt), 32'd32);
    chk("init_rd_zero", rd_a_data, 32'd0);
    wr_en = 1'b0;
    step();
    chk("init_addr7", rd_a_data, 32'd7);
    chk("init_addr31", rd_b_data, 32'd31);

    // Write/read
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEAD_BEEF;
    rd_a_addr = 5'd0; rd_b_addr = 5'd1;
    step();
    chk("rd_addr0", rd_a_data, 32'd0);
    chk("rd_addr1", rd_b_data, 32'd1);
    wr_en = 1'b0; rd_a_addr = 5'd3; rd_b_addr = 5'd4;
    step();
    chk("wr_rd_a3", rd_a_data, 32'hDEAD_BEEF);
    chk("wr_rd_b4", rd_b_data, 32'd4);

    // Forwarding with negative data, both ports on the same address
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = -32'sd5;
    rd_a_addr = 5'd10; rd_b_addr = 5'd10;
    step();
    chk("fwd_a10", rd_a_data, 32'hFFFF_FFFB);
    chk("fwd_b10", rd_b_data, 32'hFFFF_FFFB);
    wr_data = 32'h0BAD_F00D; rd_b_addr = 5'd9;
    step();
    chk("fwd_a10_new", rd_a_data, 32'h0BAD_F00D);
    chk("fwd_b9", rd_b_data, 32'd9);
    wr_en = 1'b0; rd_b_addr = 5'd10;
    step();
    chk("arr_a10", rd_a_data, 32'h0BAD_F00D);
    chk("arr_b10", rd_b_data, 32'h0BAD_F00D);

    // Re-init: write in the init_req cycle still completes and forwards
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h55;
    step();
    wr_addr = 5'd1; wr_data = 32'h66; init_req = 1'b1;
    rd_a_addr = 5'd0; rd_b_addr = 5'd1;
    step();
    chk("reinit_rd_a", rd_a_data, 32'h55);
    chk("reinit_rd_b", rd_b_data, 32'h66);
    chk("reinit_ready_low", 32'(ready), 32'd0);
    init_req = 1'b0; wr_en = 1'b0;
    wait_ready(cnt);
    chk("reinit_edges", 32'(cnt), 32'd32);
    step();
    chk("reinit_addr0", rd_a_data, 32'd0);
    chk("reinit_addr1", rd_b_data, 32'd1);

    // Asynchronous reset while in RUN clears outputs without a clock edge
    rd_a_addr = 5'd31; rd_b_addr = 5'd30;
    step();
    chk("pre_rst_a31", rd_a_data, 32'd31);
    chk("pre_rst_b30", rd_b_data, 32'd30);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", 32'(ready), 32'd0);
    chk("async_rst_rd_a", rd_a_data, 32'd0);
    chk("async_rst_rd_b", rd_b_data, 32'd0);
    step();
    rst_n = 1'b1;
    wait_ready(cnt);
    chk("rst_run_edges", 32'(cnt), 32'd32);

    // Reset mid-init: 12 init edges, reset for 3 cycles, then full restart
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("midinit_ready_low", 32'(ready), 32'd0);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("midinit_rst_ready", 32'(ready), 32'd0);
    chk("midinit_rst_rd", rd_a_data, 32'd0);
    rst_n = 1'b1;
    wait_ready(cnt);
    chk("midinit_edges", 32'(cnt), 32'd32);
    rd_a_addr = 5'd12; rd_b_addr = 5'd0;
    step();
    chk("midinit_addr12", rd_a_data, 32'd12);
    chk("midinit_addr0", rd_b_data, 32'd0);

`ifdef DATA_MEM_BANK_BYTE_EN
    // Byte-enable merge, forwarded and from the array
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'hAABB_CCDD; wr_be = 4'b0101;
    rd_a_addr = 5'd20; rd_b_addr = 5'd21;
    step();
    chk("be_fwd", rd_a_data, 32'h00BB_00DD);
    chk("be_other", rd_b_data, 32'd21);
    wr_en = 1'b0; wr_be = 4'hF;
    step();
    chk("be_arr", rd_a_data, 32'h00BB_00DD);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/data_mem_bank.md
# data_mem_bank

Parametrised data memory for PIGRO, the next-generation replacement for the fixed 32×32 data store. It provides one synchronous write port and two registered read ports, with write-to-read forwarding. A built-in init sequencer loads the identity pattern (mem[i] = i) after reset or on request, and holds `ready` low until the pattern is complete. It sits between the execute stage and the register-file writeback path.

## Interface
Parameters:
- `DATA_W`, 32: word width in bits.
- `ADDR_W`, 5: address width; DEPTH = 2^ADDR_W words.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `init_req`  in  1: one-cycle pulse that restarts the init sequence; sampled only in RUN.
- `wr_en`  in  1: write strobe.
- `wr_addr`  in  ADDR_W: write address.
- `wr_data`  in  DATA_W (signed): write data.
- `wr_be`  in  DATA_W/8: byte enables; present only with `DATA_MEM_BANK_BYTE_EN`.
- `rd_a_addr`, `rd_b_addr`  in  ADDR_W: read addresses.
- `rd_a_data`, `rd_b_data`  out  DATA_W (signed): registered read data.
- `ready`  out  1: high in RUN; accesses are honoured only while it is high.

## Operation
- FSM has two states, INIT and RUN. Counter `init_cnt` is ADDR_W bits.
- Reset (`rst_n`=0): state=INIT, `init_cnt`=0, `ready`=0, `rd_a_data`=`rd_b_data`=0. The array contents are not reset.
- INIT:
  - Each cycle writes mem[init_cnt] = init_cnt, zero-extended, or truncated if DATA_W < ADDR_W. Then `init_cnt` increments.
  - When `init_cnt`==DEPTH-1, the FSM writes the last word and goes to RUN. The counter wraps to 0.
  - `wr_en`, `wr_addr`, `wr_data` and `init_req` are ignored. Read registers load 0.
- RUN:
  - `ready`=1.
  - If `wr_en`=1: mem[wr_addr] <= `wr_data`, masked per byte by `wr_be` when that feature is compiled in.
  - Every cycle: rd_x_data <= mem[rd_x_addr].
  - Forwarding: if `wr_en`=1 and `wr_addr`==rd_x_addr in the same cycle, rd_x_data takes the merged new word, not the stale array word. This applies to each port independently.
  - Both read ports may use the same address. Each port then returns the same value.
  - `init_req`=1 moves the FSM to INIT on the next edge. A write presented in that same cycle still completes.
- Reset asserted mid-INIT or mid-RUN: the FSM returns to INIT immediately and `init_cnt`=0. Init restarts from word 0, and partial earlier writes are overwritten.

## Timing
- Read latency is 1 cycle: an address presented before edge N gives data valid after edge N.
- Write takes effect at the edge. A read of the same address in the same cycle sees the new value through forwarding. A read in the next cycle sees it from the array.
- Init takes exactly DEPTH edges after `rst_n` deasserts or after the `init_req` edge. `ready` rises after the DEPTH-th init edge.
- Once `ready` is high, the first valid read returns data one edge later.
- `ready` and `rd_*_data` change only on clock edges, or asynchronously to their reset values on `rst_n` falling.

## Configuration
- `DATA_MEM_BANK_BYTE_EN` defined:
  - The `wr_be` port exists. DATA_W must be a multiple of 8.
  - Byte k of mem[wr_addr] is written only when wr_be[k]=1. Unselected bytes keep their old value.
  - Forwarded read data is the merged word (new bytes where enabled, old bytes elsewhere).
  - Init ignores `wr_be` and writes full words.
- `DATA_MEM_BANK_BYTE_EN` not defined: there is no `wr_be` port, and every write replaces the full word.

## Test plan
DATA_W=32, ADDR_W=5 unless stated otherwise.
- **Reset/init:** release `rst_n`, hold `wr_en`=1 during init.
  - `ready`=0 for 32 edges, then 1.
  - Reading addr 7 then gives 7, and addr 31 gives 31.
  - The ignored init-time writes leave no trace.
- **Write/read:** write 0xDEADBEEF to addr 3, then on the next cycle read addr 3 on port A and addr 4 on port B.
  - A returns 0xDEADBEEF one cycle later; B returns 4.
- **Forwarding and negative data:** write −5 (0xFFFFFFFB) to addr 10 while both ports read addr 10.
  - Both ports return 0xFFFFFFFB after one edge.
  - Port B reading addr 9 in the same cycle gets 9.
- **Re-init:** write 0x55 to addr 0, then pulse `init_req` with a write of 0x66 to addr 1 in the same cycle.
  - `ready` drops for 32 cycles.
  - Afterwards addr 0 reads 0 and addr 1 reads 1.
- **Reset mid-init:** assert `rst_n`=0 at init cycle 12, release it 3 cycles later.
  - Outputs are 0 immediately and init restarts from 0.
  - `ready` rises exactly 32 edges after release.
- **Byte enables** (`DATA_MEM_BANK_BYTE_EN`): write 0xAABBCCDD to addr 20 (initial value 0x14) with `wr_be`=4'b0101, reading addr 20 in the same cycle.
  - The forwarded read gives 0x00BB00DD.
  - A later read gives 0x00BB00DD.
